// File: rtl/psram_cal_pkg.sv
// Shared definitions for the PSRAM capture-phase calibrator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package psram_cal_pkg;

  // Width of the phase_sel index; covers up to 8 selectable phases.
  localparam int PHASE_W       = 3;

  // Default sizing used by the top level when not overridden.
  localparam int DEF_NUM_PHASE = 4;
  localparam int DEF_LOCK_WAIT = 64;
  localparam int DEF_SETTLE    = 16;
  localparam int DEF_TIMEOUT   = 256;

  // Calibration sequencer states.
  typedef enum logic [2:0] {
    S_LOCKWAIT,
    S_IDLE,
    S_SETTLE,
    S_TEST,
    S_NEXT,
    S_PICK,
    S_DONE,
    S_FAIL
  } cal_state_e;

endpackage

// File: rtl/psram_lock_filter.sv
// Qualifies the PLL lock: requires LOCK_WAIT consecutive high samples of locked_i.
// Latency: lock_ok_o rises on the cycle whose edge completes the LOCK_WAIT-th high sample.
// Backpressure: none; any low sample clears the count immediately.
module psram_lock_filter #(
  parameter int LOCK_WAIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  output logic lock_ok_o
);

  localparam int CNT_W = $clog2(LOCK_WAIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive lock samples, saturating at LOCK_WAIT; a drop restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!locked_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(LOCK_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag looks at the next count so the sequencer can leave reset on the same edge
  // the count reaches LOCK_WAIT.
  assign lock_ok_o = locked_i && (cnt_d == CNT_W'(LOCK_WAIT));

endmodule

// File: rtl/psram_phase_cal.sv
// Sweeps PSRAM capture phases, then picks the centre of the longest passing run; watchdog under PHASE_CAL_TIMEOUT_EN.
// Latency: SETTLE cycles per phase before test_req, one PICK cycle, all outputs registered.
// Backpressure: test_req held until test_ack (or watchdog expiry); cal_start ignored while a sweep runs.
module psram_phase_cal
  import psram_cal_pkg::*;
#(
  parameter int NUM_PHASE = DEF_NUM_PHASE,
  parameter int LOCK_WAIT = DEF_LOCK_WAIT,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic                 cal_start,
  output logic                 ctrl_rst,
  output logic [PHASE_W-1:0]   phase_sel,
  output logic                 test_req,
  input  logic                 test_ack,
  input  logic                 test_pass,
  output logic [NUM_PHASE-1:0] pass_mask,
  output logic                 cal_done,
  output logic                 cal_fail
);

  // One shared counter serves the settle delay and, when enabled, the test watchdog.
  localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = PHASE_W + 1;

  cal_state_e             state_q, state_d;
  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [NUM_PHASE-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic                   crst_q, crst_d;
  logic                   lock_ok;

  logic [LEN_W-1:0]       run_len, run_start;
  logic [LEN_W-1:0]       best_len, best_start;
  logic [PHASE_W-1:0]     pick_phase;

  psram_lock_filter #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_filter (
    .clk_i     (clk),
    .rst_i     (rst),
    .locked_i  (locked),
    .lock_ok_o (lock_ok)
  );

  // Longest run of passing phases, scanned low to high without wrap; strict '>' keeps the lowest start on ties.
  always_comb begin
    run_len    = '0;
    run_start  = '0;
    best_len   = '0;
    best_start = '0;
    for (int i = 0; i < NUM_PHASE; i++) begin
      if (mask_q[i]) begin
        if (run_len == '0) begin
          run_start = LEN_W'(i);
        end
        run_len = run_len + 1'b1;
        if (run_len > best_len) begin
          best_len   = run_len;
          best_start = run_start;
        end
      end else begin
        run_len = '0;
      end
    end
  end

  // Centre of the winning run, rounding toward its start for even lengths.
  assign pick_phase = PHASE_W'(best_start + ((best_len - 1'b1) >> 1));

  // Sequencer next-state and output logic; lock loss outranks every other input.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    done_d  = done_q;
    fail_d  = fail_q;
    crst_d  = crst_q;

    if ((state_q != S_LOCKWAIT) && !locked) begin
      state_d = S_LOCKWAIT;
      crst_d  = 1'b1;
      req_d   = 1'b0;
      done_d  = 1'b0;
      fail_d  = 1'b0;
      mask_d  = '0;
      phase_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_LOCKWAIT: begin
          if (lock_ok) begin
            state_d = S_IDLE;
            crst_d  = 1'b0;
          end
        end
        S_IDLE, S_DONE, S_FAIL: begin
          if (cal_start) begin
            state_d = S_SETTLE;
            mask_d  = '0;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            phase_d = '0;
            cnt_d   = '0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE - 1)) begin
            state_d = S_TEST;
            req_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_TEST: begin
          if (req_q && test_ack) begin
            for (int i = 0; i < NUM_PHASE; i++) begin
              if (PHASE_W'(i) == phase_q) begin
                mask_d[i] = test_pass;
              end
            end
            req_d   = 1'b0;
            state_d = S_NEXT;
            cnt_d   = '0;
          end
`ifdef PHASE_CAL_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // No answer within TIMEOUT cycles of test_req rising: score the phase as failed.
            for (int i = 0; i < NUM_PHASE; i++) begin
              if (PHASE_W'(i) == phase_q) begin
                mask_d[i] = 1'b0;
              end
            end
            req_d   = 1'b0;
            state_d = S_NEXT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          // Without the watchdog the sweep waits on test_ack indefinitely.
`endif
        end
        S_NEXT: begin
          if (phase_q == PHASE_W'(NUM_PHASE - 1)) begin
            state_d = S_PICK;
          end else begin
            phase_d = phase_q + 1'b1;
            state_d = S_SETTLE;
            cnt_d   = '0;
          end
        end
        S_PICK: begin
          if (best_len != '0) begin
            phase_d = pick_phase;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            phase_d = '0;
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end
        end
        default: begin
          state_d = S_LOCKWAIT;
        end
      endcase
    end
  end

  // State and output registers; controller held in reset until lock qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOCKWAIT;
      phase_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      crst_q  <= crst_d;
    end
  end

  assign ctrl_rst  = crst_q;
  assign phase_sel = phase_q;
  assign test_req  = req_q;
  assign pass_mask = mask_q;
  assign cal_done  = done_q;
  assign cal_fail  = fail_q;

endmodule

// File: tb/tb_psram_phase_cal.sv
// Self-checking bench for psram_phase_cal: lock qualification, sweeps, pick rules, lock loss, reset.
// Latency expectations come from the bench's own timing rules and a brute-force pick model.
// Runs the watchdog scenario when PHASE_CAL_TIMEOUT_EN is defined, the stall scenario otherwise.
module tb_psram_phase_cal;
  import psram_cal_pkg::*;

  localparam int NP  = 4;
  localparam int LW  = 64;
  localparam int SET = 16;
  localparam int TO  = 256;

  logic               clk;
  logic               rst;
  logic               locked;
  logic               cal_start;
  logic               ctrl_rst;
  logic [PHASE_W-1:0] phase_sel;
  logic               test_req;
  logic               test_ack;
  logic               test_pass;
  logic [NP-1:0]      pass_mask;
  logic               cal_done;
  logic               cal_fail;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [NP-1:0] res;
    logic [NP-1:0] exp_mask;
    int            exp_phase;
    bit            exp_done;
    bit            exp_fail;
  } vec_t;

  vec_t vecs [8];

  psram_phase_cal #(
    .NUM_PHASE (NP),
    .LOCK_WAIT (LW),
    .SETTLE    (SET),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .cal_start (cal_start),
    .ctrl_rst  (ctrl_rst),
    .phase_sel (phase_sel),
    .test_req  (test_req),
    .test_ack  (test_ack),
    .test_pass (test_pass),
    .pass_mask (pass_mask),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_timeout: summary not reached");
    $fatal(1, "bench stopped");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Brute force over every (start, end) window; first strictly longer window wins.
  function automatic int ref_pick(input logic [NP-1:0] m);
    int best_s = 0;
    int best_l = 0;
    bit all1;
    for (int s = 0; s < NP; s++) begin
      for (int e = s; e < NP; e++) begin
        all1 = 1'b1;
        for (int k = s; k <= e; k++) if (!m[k]) all1 = 1'b0;
        if (all1 && (e - s + 1) > best_l) begin
          best_l = e - s + 1;
          best_s = s;
        end
      end
    end
    return (best_l == 0) ? 0 : best_s + (best_l - 1) / 2;
  endfunction

  task automatic wait_req(output int w);
    w = 0;
    while (!test_req && w < 1000) begin
      tick();
      w++;
    end
  endtask

  task automatic ack_now(input logic pass);
    test_ack  = 1'b1;
    test_pass = pass;
    tick();
    test_ack  = 1'b0;
    test_pass = 1'b0;
  endtask

  task automatic wait_status();
    int w;
    w = 0;
    while (!(cal_done || cal_fail) && w < 50) begin
      tick();
      w++;
    end
    chk("status_seen", int'(cal_done || cal_fail), 1);
  endtask

  // Full sweep with timing checks; noise adds stray acks and cal_starts that must be ignored.
  task automatic run_sweep(input logic [NP-1:0] res, input bit noise);
    int w;
    int dly;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("start_clr_status", int'({cal_done, cal_fail}), 0);
    chk("start_clr_mask", int'(pass_mask), 0);
    for (int p = 0; p < NP; p++) begin
      w = 0;
      while (!test_req && w < 1000) begin
        if (noise) begin
          test_ack  = ($urandom_range(0, 2) == 0);
          test_pass = 1'b1;
          cal_start = ($urandom_range(0, 3) == 0);
        end
        tick();
        w++;
      end
      test_ack  = 1'b0;
      test_pass = 1'b0;
      cal_start = 1'b0;
      chk("settle_gap", w, (p == 0) ? SET : SET + 1);
      chk("phase_at_req", int'(phase_sel), p);
      dly = noise ? int'($urandom_range(0, 4)) : 0;
      repeat (dly) tick();
      chk("req_held", int'(test_req), 1);
      ack_now(res[p]);
      chk("req_drop", int'(test_req), 0);
    end
    w = 0;
    while (!(cal_done || cal_fail) && w < 50) begin
      tick();
      w++;
    end
    chk("pick_latency", w, 2);
  endtask

  // Starts a sweep and answers phases below target, leaving test_req up at target.
  task automatic go_to_phase(input int target, input logic [NP-1:0] res);
    int w;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int p = 0; p <= target; p++) begin
      wait_req(w);
      chk("gp_req", int'(test_req), 1);
      chk("gp_phase", int'(phase_sel), p);
      if (p < target) ack_now(res[p]);
    end
  endtask

  task automatic finish_from(input int first, input logic [NP-1:0] res);
    int w;
    for (int p = first; p < NP; p++) begin
      wait_req(w);
      chk("ff_phase", int'(phase_sel), p);
      ack_now(res[p]);
    end
    wait_status();
  endtask

  initial begin : main
    int            w;
    int            seen;
    logic [NP-1:0] r;

    vecs[0] = '{4'b1110, 4'b1110, 2, 1'b1, 1'b0};
    vecs[1] = '{4'b1101, 4'b1101, 2, 1'b1, 1'b0};
    vecs[2] = '{4'b0011, 4'b0011, 0, 1'b1, 1'b0};
    vecs[3] = '{4'b0101, 4'b0101, 0, 1'b1, 1'b0};
    vecs[4] = '{4'b0000, 4'b0000, 0, 1'b0, 1'b1};
    vecs[5] = '{4'b1111, 4'b1111, 1, 1'b1, 1'b0};
    vecs[6] = '{4'b1000, 4'b1000, 3, 1'b1, 1'b0};
    vecs[7] = '{4'b0110, 4'b0110, 1, 1'b1, 1'b0};

    // Reset wins over every other input.
    rst       = 1'b1;
    locked    = 1'b1;
    cal_start = 1'b1;
    test_ack  = 1'b1;
    test_pass = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl_rst", int'(ctrl_rst), 1);
    chk("rst_phase", int'(phase_sel), 0);
    chk("rst_req", int'(test_req), 0);
    chk("rst_mask", int'(pass_mask), 0);
    chk("rst_done", int'(cal_done), 0);
    chk("rst_fail", int'(cal_fail), 0);

    // Lock qualification with one glitch restarting the count.
    locked    = 1'b0;
    cal_start = 1'b0;
    test_ack  = 1'b0;
    test_pass = 1'b0;
    rst       = 1'b0;
    repeat (5) tick();
    locked = 1'b1;
    repeat (25) tick();
    chk("lock_pre_glitch", int'(ctrl_rst), 1);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    w = 0;
    while (ctrl_rst && w < 200) begin
      tick();
      w++;
    end
    chk("lock_wait_cycles", w, LW);
    chk("idle_no_req", int'(test_req), 0);

    // Directed pick vectors.
    for (int i = 0; i < 8; i++) begin
      run_sweep(vecs[i].res, 1'b0);
      chk("vec_mask", int'(pass_mask), int'(vecs[i].exp_mask));
      chk("vec_phase", int'(phase_sel), vecs[i].exp_phase);
      chk("vec_done", int'(cal_done), int'(vecs[i].exp_done));
      chk("vec_fail", int'(cal_fail), int'(vecs[i].exp_fail));
    end

    // Random results against the reference pick model.
    for (int i = 0; i < 20; i++) begin
      r = NP'($urandom_range(0, (1 << NP) - 1));
      run_sweep(r, 1'b1);
      chk("rnd_mask", int'(pass_mask), int'(r));
      chk("rnd_phase", int'(phase_sel), ref_pick(r));
      chk("rnd_done", int'(cal_done), int'(r != '0));
      chk("rnd_fail", int'(cal_fail), int'(r == '0));
    end

    // Unanswered test at phase 1.
    go_to_phase(1, 4'b1111);
`ifdef PHASE_CAL_TIMEOUT_EN
    w = 0;
    while (test_req && w < 1000) begin
      tick();
      w++;
    end
    chk("timeout_len", w, TO);
    chk("timeout_mask1", int'(pass_mask[1]), 0);
`else
    repeat (300) tick();
    chk("stall_req_held", int'(test_req), 1);
    chk("stall_phase", int'(phase_sel), 1);
    ack_now(1'b0);
`endif
    finish_from(2, 4'b1101);
    chk("stall_mask", int'(pass_mask), 4'b1101);
    chk("stall_phase_pick", int'(phase_sel), 2);
    chk("stall_done", int'(cal_done), 1);

    // Lock loss during phase 2, coincident with ack and cal_start.
    go_to_phase(2, 4'b1111);
    locked    = 1'b0;
    test_ack  = 1'b1;
    test_pass = 1'b1;
    cal_start = 1'b1;
    tick();
    test_ack  = 1'b0;
    test_pass = 1'b0;
    cal_start = 1'b0;
    chk("loss_ctrl_rst", int'(ctrl_rst), 1);
    chk("loss_req", int'(test_req), 0);
    chk("loss_mask", int'(pass_mask), 0);
    chk("loss_phase", int'(phase_sel), 0);
    chk("loss_status", int'({cal_done, cal_fail}), 0);
    locked = 1'b1;
    w = 0;
    while (ctrl_rst && w < 200) begin
      tick();
      w++;
    end
    chk("relock_cycles", w, LW);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (test_req) seen++;
    end
    chk("no_resume", seen, 0);

    // Reset in the middle of a sweep.
    go_to_phase(1, 4'b1111);
    rst       = 1'b1;
    test_ack  = 1'b1;
    test_pass = 1'b1;
    tick();
    rst       = 1'b0;
    test_ack  = 1'b0;
    test_pass = 1'b0;
    chk("mid_rst_ctrl_rst", int'(ctrl_rst), 1);
    chk("mid_rst_req", int'(test_req), 0);
    chk("mid_rst_mask", int'(pass_mask), 0);
    chk("mid_rst_phase", int'(phase_sel), 0);
    w = 0;
    while (ctrl_rst && w < 200) begin
      tick();
      w++;
    end
    chk("mid_rst_relock", w, LW);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
